// File: rtl/mem_port_arbiter.sv
// Shares one MMU-style data port among NUM_CH requesters. Grants are
// round-robin or fixed-priority, faults are reported per channel, and a
// watchdog aborts accesses that stay in wait too long.
module mem_port_arbiter #(
  parameter int unsigned NUM_CH   = 2,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MODE     = 0,
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        req,
  input  logic [NUM_CH-1:0]        we,
  input  logic [NUM_CH*ADDR_W-1:0] addr,
  input  logic [NUM_CH*DATA_W-1:0] wdata,
  output logic [NUM_CH-1:0]        ack,
  output logic [NUM_CH-1:0]        fault,
  output logic [DATA_W-1:0]        rdata,
  output logic                     busy,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  output logic                     mem_rd,
  output logic                     mem_wd,
  input  logic [DATA_W-1:0]        mem_rdata,
  input  logic                     mem_wait,
  input  logic                     mem_segv
);

  localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned CNT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MAX_WAIT);
  localparam logic [CH_W-1:0]  LAST_RST  = CH_W'(NUM_CH - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_e;

  state_e              state_q, state_d;
  logic [CH_W-1:0]     gnt_q, gnt_d;
  logic [CH_W-1:0]     last_q, last_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NUM_CH-1:0]   ack_q, ack_d;
  logic [NUM_CH-1:0]   fault_q, fault_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                rd_q, rd_d;
  logic                wd_q, wd_d;
  logic                busy_q, busy_d;

  logic [CH_W-1:0]     cand_c;
  logic [CH_W-1:0]     gnt_c;
  logic                found_c;
  logic [CNT_W-1:0]    cnt_inc_c;

  // Grant search: lowest index in fixed mode, first set bit after last_q otherwise.
  always_comb begin
    cand_c  = '0;
    gnt_c   = '0;
    found_c = 1'b0;
    for (int unsigned o = 0; o < NUM_CH; o++) begin
      if (MODE != 0) cand_c = CH_W'(o);
      else           cand_c = CH_W'((32'(last_q) + o + 32'd1) % NUM_CH);
      if (!found_c && req[cand_c]) begin
        found_c = 1'b1;
        gnt_c   = cand_c;
      end
    end
  end

  // Next-state and next-output logic for the IDLE/BUSY/RESP sequence.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    ack_d     = '0;
    fault_d   = '0;
    rdata_d   = rdata_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rd_d      = 1'b0;
    wd_d      = 1'b0;
    busy_d    = 1'b0;
    cnt_inc_c = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    case (state_q)
      S_IDLE: begin
        if (found_c) begin
          state_d = S_BUSY;
          gnt_d   = gnt_c;
          last_d  = gnt_c;
          cnt_d   = '0;
          addr_d  = addr[32'(gnt_c) * ADDR_W +: ADDR_W];
          wdata_d = wdata[32'(gnt_c) * DATA_W +: DATA_W];
          rd_d    = ~we[gnt_c];
          wd_d    = we[gnt_c];
          busy_d  = 1'b1;
        end
      end
      S_BUSY: begin
        busy_d = 1'b1;
        if (!mem_wait) begin
          // Completion wins over a watchdog expiry on the same edge.
          state_d        = S_RESP;
          ack_d[gnt_q]   = 1'b1;
          fault_d[gnt_q] = mem_segv;
          rdata_d        = wd_q ? '0 : mem_rdata;
        end else if ((MAX_WAIT != 0) && (cnt_inc_c == CNT_LIMIT)) begin
          state_d        = S_RESP;
          cnt_d          = cnt_inc_c;
          ack_d[gnt_q]   = 1'b1;
          fault_d[gnt_q] = 1'b1;
          rdata_d        = '0;
        end else begin
          cnt_d = cnt_inc_c;
          rd_d  = rd_q;
          wd_d  = wd_q;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset drops any in-flight access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      last_q  <= LAST_RST;
      cnt_q   <= '0;
      ack_q   <= '0;
      fault_q <= '0;
      rdata_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= 1'b0;
      wd_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      fault_q <= fault_d;
      rdata_q <= rdata_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      wd_q    <= wd_d;
      busy_q  <= busy_d;
    end
  end

  assign ack       = ack_q;
  assign fault     = fault_q;
  assign rdata     = rdata_q;
  assign busy      = busy_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_rd    = rd_q;
  assign mem_wd    = wd_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (round-robin with watchdog 6,
// fixed priority with watchdog 4), directed vectors plus a transaction-level
// reference model driven by randomized requesters and memory.
module tb_mem_port_arbiter;

  localparam int unsigned NC = 3;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned ND = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [NC-1:0] req [ND];
  logic [NC-1:0] we [ND];
  logic [NC*AW-1:0] addr [ND];
  logic [NC*DW-1:0] wdata [ND];
  logic [NC-1:0] ack [ND];
  logic [NC-1:0] fault [ND];
  logic [DW-1:0] rdata [ND];
  logic          busy [ND];
  logic [AW-1:0] mem_addr [ND];
  logic [DW-1:0] mem_wdata [ND];
  logic          mem_rd [ND];
  logic          mem_wd [ND];
  logic [DW-1:0] mem_rdata [ND];
  logic          mem_wait [ND];
  logic          mem_segv [ND];

  mem_port_arbiter #(.NUM_CH(NC), .ADDR_W(AW), .DATA_W(DW), .MODE(0), .MAX_WAIT(6)) u_rr (
    .clk(clk), .rst_n(rst_n), .req(req[0]), .we(we[0]), .addr(addr[0]), .wdata(wdata[0]),
    .ack(ack[0]), .fault(fault[0]), .rdata(rdata[0]), .busy(busy[0]),
    .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]), .mem_rd(mem_rd[0]), .mem_wd(mem_wd[0]),
    .mem_rdata(mem_rdata[0]), .mem_wait(mem_wait[0]), .mem_segv(mem_segv[0]));

  mem_port_arbiter #(.NUM_CH(NC), .ADDR_W(AW), .DATA_W(DW), .MODE(1), .MAX_WAIT(4)) u_fp (
    .clk(clk), .rst_n(rst_n), .req(req[1]), .we(we[1]), .addr(addr[1]), .wdata(wdata[1]),
    .ack(ack[1]), .fault(fault[1]), .rdata(rdata[1]), .busy(busy[1]),
    .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]), .mem_rd(mem_rd[1]), .mem_wd(mem_wd[1]),
    .mem_rdata(mem_rdata[1]), .mem_wait(mem_wait[1]), .mem_segv(mem_segv[1]));

  int n_vec = 0;
  int n_err = 0;

  function automatic int mode_of(input int d);
    return (d == 0) ? 0 : 1;
  endfunction

  function automatic int maxw_of(input int d);
    return (d == 0) ? 6 : 4;
  endfunction

  task automatic chk(input string name, input int d, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d t=%0t: got %0h expected %0h", name, d, $time, act, exp);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  int            m_last [ND];
  bit            m_open [ND];
  int            m_gap  [ND];
  int            m_k    [ND];
  int            m_len  [ND];
  int            m_w    [ND];
  int            m_ch   [ND];
  bit            m_to   [ND];
  bit            m_we   [ND];
  bit            m_sg   [ND];
  logic [DW-1:0] m_mrd  [ND];
  logic [DW-1:0] m_rdata[ND];
  logic [AW-1:0] m_addr [ND];
  logic [DW-1:0] m_wdat [ND];
  int            glog [ND][8];
  int            gcnt [ND];
  bit            continuous;

  function automatic int pick(input int mode, input logic [NC-1:0] r, input int last);
    for (int o = 0; o < int'(NC); o++) begin
      int i;
      i = (mode == 1) ? o : (last + 1 + o) % int'(NC);
      if (r[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < int'(ND); d++) begin
      m_last[d]  = int'(NC) - 1;
      m_open[d]  = 1'b0;
      m_gap[d]   = 0;
      m_rdata[d] = '0;
      gcnt[d]    = 0;
    end
  endtask

  task automatic new_req(input int d, input int c);
    req[d][c]            = 1'b1;
    we[d][c]             = 1'($urandom_range(0, 1));
    addr[d][c*AW +: AW]  = $urandom;
    wdata[d][c*DW +: DW] = $urandom;
  endtask

  task automatic exp_out(input int d, input bit e_busy, input bit e_rd, input bit e_wd,
                         input logic [NC-1:0] e_ack, input logic [NC-1:0] e_fault, input bit bus);
    chk("busy",   d, 64'(busy[d]),   64'(e_busy));
    chk("mem_rd", d, 64'(mem_rd[d]), 64'(e_rd));
    chk("mem_wd", d, 64'(mem_wd[d]), 64'(e_wd));
    chk("ack",    d, 64'(ack[d]),    64'(e_ack));
    chk("fault",  d, 64'(fault[d]),  64'(e_fault));
    chk("rdata",  d, 64'(rdata[d]),  64'(m_rdata[d]));
    if (bus) begin
      chk("mem_addr",  d, 64'(mem_addr[d]),  64'(m_addr[d]));
      chk("mem_wdata", d, 64'(mem_wdata[d]), 64'(m_wdat[d]));
    end
  endtask

  // One negedge of the model for DUT d: check outputs, then drive memory and requesters.
  task automatic step(input int d);
    logic [NC-1:0] r, oh;
    int acked, a_idx;
    r     = req[d];
    acked = -1;
    if (m_open[d]) begin
      m_k[d]++;
      if (m_k[d] <= m_len[d]) begin
        exp_out(d, 1'b1, !m_we[d], m_we[d], '0, '0, 1'b1);
      end else begin
        oh         = NC'(1) << m_ch[d];
        m_rdata[d] = (m_to[d] || m_we[d]) ? '0 : m_mrd[d];
        exp_out(d, 1'b1, 1'b0, 1'b0, oh, (m_to[d] || m_sg[d]) ? oh : '0, 1'b0);
        a_idx = -1;
        for (int c = 0; c < int'(NC); c++) if (ack[d][c]) a_idx = c;
        if (gcnt[d] < 8) glog[d][gcnt[d]] = a_idx;
        gcnt[d]++;
        m_open[d] = 1'b0;
        m_gap[d]  = 1;
        acked     = m_ch[d];
      end
    end else if (m_gap[d] > 0) begin
      m_gap[d]--;
      exp_out(d, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    end else if (r != '0) begin
      m_ch[d] = pick(mode_of(d), r, m_last[d]);
      if (mode_of(d) == 0) m_last[d] = m_ch[d];
      m_we[d]   = we[d][m_ch[d]];
      m_addr[d] = addr[d][m_ch[d]*AW +: AW];
      m_wdat[d] = wdata[d][m_ch[d]*DW +: DW];
      m_w[d]    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, maxw_of(d) + 2))
                                              : int'($urandom_range(0, 2));
      m_sg[d]   = ($urandom_range(0, 7) == 0);
      m_mrd[d]  = $urandom;
      m_to[d]   = (maxw_of(d) != 0) && (m_w[d] >= maxw_of(d));
      m_len[d]  = m_to[d] ? maxw_of(d) : m_w[d] + 1;
      m_open[d] = 1'b1;
      m_k[d]    = 1;
      exp_out(d, 1'b1, !m_we[d], m_we[d], '0, '0, 1'b1);
    end else begin
      exp_out(d, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    end
    if (m_open[d]) begin
      mem_wait[d]  = (m_k[d] <= m_w[d]);
      mem_rdata[d] = m_mrd[d];
      mem_segv[d]  = m_sg[d];
    end else begin
      mem_wait[d]  = 1'($urandom_range(0, 1));
      mem_rdata[d] = $urandom;
      mem_segv[d]  = 1'($urandom_range(0, 1));
    end
    for (int c = 0; c < int'(NC); c++) begin
      if (c == acked) begin
        if (continuous || $urandom_range(0, 1) == 1) new_req(d, c);
        else req[d][c] = 1'b0;
      end else if (!req[d][c] && !continuous && $urandom_range(0, 3) == 0) begin
        new_req(d, c);
      end
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    int            d;
    int            ch;
    bit            we;
    logic [AW-1:0] a;
    logic [DW-1:0] wd;
    int            w;
    bit            segv;
    logic [DW-1:0] mrd;
    logic [NC-1:0] e_ack;
    logic [NC-1:0] e_fault;
    logic [DW-1:0] e_rdata;
    int            e_len;
  } vec_t;

  vec_t tv [7];

  function automatic vec_t mk(input int d, input int ch, input bit w_e, input logic [AW-1:0] a,
                              input logic [DW-1:0] wd, input int w, input bit segv,
                              input logic [DW-1:0] mrd, input logic [NC-1:0] e_ack,
                              input logic [NC-1:0] e_fault, input logic [DW-1:0] e_rdata,
                              input int e_len);
    vec_t v;
    v.d = d; v.ch = ch; v.we = w_e; v.a = a; v.wd = wd; v.w = w; v.segv = segv; v.mrd = mrd;
    v.e_ack = e_ack; v.e_fault = e_fault; v.e_rdata = e_rdata; v.e_len = e_len;
    return v;
  endfunction

  task automatic apply_vec(input vec_t v, input int id);
    int  n, bad, d;
    bit  got;
    d = v.d;
    req[d][v.ch]             = 1'b1;
    we[d][v.ch]              = v.we;
    addr[d][v.ch*AW +: AW]   = v.a;
    wdata[d][v.ch*DW +: DW]  = v.wd;
    mem_rdata[d] = v.mrd;
    mem_segv[d]  = v.segv;
    mem_wait[d]  = 1'b0;
    n = 0; bad = 0; got = 1'b0;
    while (!got && n < 20) begin
      @(negedge clk);
      if (ack[d] != '0) begin
        got = 1'b1;
      end else begin
        n++;
        if (mem_addr[d] !== v.a || mem_wdata[d] !== v.wd || mem_rd[d] !== !v.we ||
            mem_wd[d] !== v.we || busy[d] !== 1'b1) bad++;
        mem_wait[d] = (n <= v.w);
      end
    end
    chk($sformatf("v%0d_ack_seen", id),  d, 64'(got),     64'(1));
    chk($sformatf("v%0d_ack", id),       d, 64'(ack[d]),  64'(v.e_ack));
    chk($sformatf("v%0d_fault", id),     d, 64'(fault[d]), 64'(v.e_fault));
    chk($sformatf("v%0d_rdata", id),     d, 64'(rdata[d]), 64'(v.e_rdata));
    chk($sformatf("v%0d_busy_len", id),  d, 64'(n),       64'(v.e_len));
    chk($sformatf("v%0d_bus_hold", id),  d, 64'(bad),     64'(0));
    chk($sformatf("v%0d_resp_strb", id), d, 64'({mem_rd[d], mem_wd[d]}), 64'(0));
    req[d][v.ch] = 1'b0;
    mem_wait[d]  = 1'b0;
    @(negedge clk);
    chk($sformatf("v%0d_idle_busy", id),  d, 64'(busy[d]),  64'(0));
    chk($sformatf("v%0d_idle_ack", id),   d, 64'(ack[d]),   64'(0));
    chk($sformatf("v%0d_rdata_hold", id), d, 64'(rdata[d]), 64'(v.e_rdata));
  endtask

  task automatic chk_all_zero(input string tag, input int d);
    chk({tag, "_ack"},       d, 64'(ack[d]),       64'(0));
    chk({tag, "_fault"},     d, 64'(fault[d]),     64'(0));
    chk({tag, "_rdata"},     d, 64'(rdata[d]),     64'(0));
    chk({tag, "_mem_addr"},  d, 64'(mem_addr[d]),  64'(0));
    chk({tag, "_mem_wdata"}, d, 64'(mem_wdata[d]), 64'(0));
    chk({tag, "_mem_rd"},    d, 64'(mem_rd[d]),    64'(0));
    chk({tag, "_mem_wd"},    d, 64'(mem_wd[d]),    64'(0));
    chk({tag, "_busy"},      d, 64'(busy[d]),      64'(0));
  endtask

  int exp_order [ND][6];

  initial begin
    tv[0] = mk(0, 0, 1'b0, 32'h0000_1000, 32'h0,          0,  1'b0, 32'hDEAD_BEEF, 3'b001, 3'b000, 32'hDEAD_BEEF, 1);
    tv[1] = mk(0, 1, 1'b1, 32'h0000_2000, 32'h1234_5678,  5,  1'b0, 32'hAAAA_0000, 3'b010, 3'b000, 32'h0,         6);
    tv[2] = mk(0, 1, 1'b0, 32'h0000_3004, 32'h0,          2,  1'b1, 32'hCAFE_0001, 3'b010, 3'b010, 32'hCAFE_0001, 3);
    tv[3] = mk(1, 2, 1'b0, 32'h0000_4008, 32'h0,          99, 1'b0, 32'h9999_9999, 3'b100, 3'b100, 32'h0,         4);
    tv[4] = mk(0, 2, 1'b0, 32'h0000_500C, 32'h0,          6,  1'b0, 32'h7777_7777, 3'b100, 3'b100, 32'h0,         6);
    tv[5] = mk(0, 0, 1'b0, 32'h0000_6010, 32'h0,          5,  1'b0, 32'h55AA_55AA, 3'b001, 3'b000, 32'h55AA_55AA, 6);
    tv[6] = mk(1, 0, 1'b1, 32'h0000_7014, 32'hFEED_F00D,  3,  1'b1, 32'h1111_1111, 3'b001, 3'b001, 32'h0,         4);
    for (int i = 0; i < 6; i++) begin
      exp_order[0][i] = i % 3;
      exp_order[1][i] = 0;
    end

    rst_n = 1'b0;
    continuous = 1'b0;
    for (int d = 0; d < int'(ND); d++) begin
      req[d] = '0; we[d] = '0; addr[d] = '0; wdata[d] = '0;
      mem_rdata[d] = '0; mem_wait[d] = 1'b0; mem_segv[d] = 1'b0;
    end
    #12;
    for (int d = 0; d < int'(ND); d++) chk_all_zero("por", d);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    for (int d = 0; d < int'(ND); d++) chk("idle_busy", d, 64'(busy[d]), 64'(0));

    for (int i = 0; i < 7; i++) apply_vec(tv[i], i);

    // Reset in the middle of an access: ch2 busy, ch0/ch1 pending behind it.
    for (int d = 0; d < int'(ND); d++) begin
      new_req(d, 2);
      mem_wait[d] = 1'b1;
    end
    @(negedge clk);
    for (int d = 0; d < int'(ND); d++) begin
      chk("pre_rst_busy", d, 64'(busy[d]), 64'(1));
      chk("pre_rst_addr", d, 64'(mem_addr[d]), 64'(addr[d][2*AW +: AW]));
      new_req(d, 0);
      new_req(d, 1);
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    for (int d = 0; d < int'(ND); d++) chk_all_zero("rst_mid", d);
    @(negedge clk);
    for (int d = 0; d < int'(ND); d++) chk("rst_no_ack", d, 64'(ack[d]), 64'(0));
    rst_n = 1'b1;
    model_reset();

    continuous = 1'b1;
    repeat (80) begin
      @(negedge clk);
      for (int d = 0; d < int'(ND); d++) step(d);
    end
    for (int d = 0; d < int'(ND); d++) begin
      for (int i = 0; i < 6; i++) begin
        chk($sformatf("grant_order%0d", i), d,
            64'((gcnt[d] > i) ? glog[d][i] : -1), 64'(exp_order[d][i]));
      end
    end

    continuous = 1'b0;
    repeat (3000) begin
      @(negedge clk);
      for (int d = 0; d < int'(ND); d++) step(d);
    end
    for (int d = 0; d < int'(ND); d++) chk("random_progress", d, 64'(gcnt[d] > 100), 64'(1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Parametrised N-channel arbiter that shares one MMU-style memory port (addr, wdata, rd/wd strobes, wait, segv) among several requesters.
- Typical requesters: instruction fetch, data load/store, a future DMA.
- Sits between the core top level and the MMU. It replaces the tied-off data port with real, arbitrated read/write traffic.
- Adds round-robin or fixed-priority selection, per-channel fault reporting and a wait-timeout watchdog.

Parameters:
- NUM_CH, 2, number of requester channels (1..8); channel 0 is highest priority in fixed mode.
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MODE, 0, 0 = round-robin, 1 = fixed priority (lowest index wins).
- MAX_WAIT, 255, BUSY cycles with mem_wait high before abort; 0 disables the watchdog.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  NUM_CH  per-channel request level.
- we  in  NUM_CH  per-channel write enable (1 = write, 0 = read).
- addr  in  NUM_CH*ADDR_W  flattened addresses; channel i occupies bits [i*ADDR_W +: ADDR_W].
- wdata  in  NUM_CH*DATA_W  flattened write data, same packing as addr.
- ack  out  NUM_CH  one-cycle completion pulse, one-hot.
- fault  out  NUM_CH  valid with ack; 1 = segv or timeout.
- rdata  out  DATA_W  read data, valid with ack.
- busy  out  1  high in BUSY or RESP.
- mem_addr  out  ADDR_W  to MMU data_addr.
- mem_wdata  out  DATA_W  to MMU data_in.
- mem_rd  out  1  to MMU rd.
- mem_wd  out  1  to MMU wd.
- mem_rdata  in  DATA_W  from MMU data.
- mem_wait  in  1  from MMU wait_data; high = not done.
- mem_segv  in  1  from MMU data_segv; sampled at completion.

Behaviour:
- Reset (asynchronous, immediate, also mid-transaction):
  - state = IDLE.
  - ack, fault, rdata, mem_addr, mem_wdata, mem_rd, mem_wd, busy = 0.
  - Wait counter = 0.
  - RR pointer last = NUM_CH-1, so channel 0 wins first.
  - Any in-flight access is dropped with no ack.
- Requester rule:
  - req, we, addr and wdata are held stable from assertion until the cycle ack[i] is seen.
  - req drops the cycle after ack.
  - Changes before ack are undefined.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - If any req is high at the edge, pick grant g and go to BUSY.
  - Latch addr[g], wdata[g] and we[g] into mem_addr, mem_wdata and mem_wd/mem_rd (mem_rd = ~we[g], mem_wd = we[g]).
  - Clear the wait counter.
  - Round-robin: first set req bit searching from last+1 upward, wrapping modulo NUM_CH; last updated to g.
  - Fixed priority: lowest set index.
  - NUM_CH = 1: always channel 0.
- BUSY:
  - Strobes and address are held.
  - If mem_wait = 0 at the edge, go to RESP with:
    - rdata = mem_rdata on a read, or 0 on a write;
    - fault[g] = mem_segv;
    - ack[g] = 1.
  - Otherwise increment the wait counter.
  - If MAX_WAIT != 0 and the counter reaches MAX_WAIT, go to RESP with ack[g] = 1, fault[g] = 1, rdata = 0.
  - Completion takes precedence over timeout on the same edge.
- RESP:
  - ack/fault are valid for exactly one cycle.
  - mem_rd and mem_wd are 0.
  - Next state is always IDLE; ack/fault clear.
  - rdata holds its value until the next RESP.
- Latency:
  - req sampled at edge k gives ack high during cycle k+2 at best (zero-wait memory).
  - Back-to-back throughput is one access per 3 cycles minimum.
- Requests arriving during BUSY or RESP wait. Simultaneous requests are resolved only in IDLE.
- Wait counter width is clog2(MAX_WAIT+1) and saturates; it never wraps.

Test Plan:
- Single read, channel 0, zero-wait: mem_rdata = 0xDEADBEEF. Expect mem_rd high one cycle with mem_addr = addr0, then ack = 2'b01, fault = 0, rdata = 0xDEADBEEF two cycles after req.
- Write on channel 1 with mem_wait high 5 cycles, wdata1 = 0x12345678. Expect mem_wd held 6 cycles with mem_wdata = 0x12345678, then ack = 2'b10, rdata = 0.
- MODE = 0, NUM_CH = 3, all req held continuously (each re-asserted after its ack). Expect grant order 0, 1, 2, 0, 1, 2. MODE = 1 with the same stimulus: channel 0 wins every arbitration.
- mem_segv = 1 at completion of a read on channel 1. Expect ack[1] = 1 and fault[1] = 1 in the same cycle, then a return to IDLE.
- MAX_WAIT = 4, mem_wait stuck high. Expect ack with fault = 1 and rdata = 0 after exactly 4 BUSY cycles; mem_rd low in RESP.
- rst_n pulsed low mid-BUSY. Expect all outputs 0 immediately and no ack. After release, a pending req on channel 0 is served first.
